race_start_sequencer: RTL and testbench

- Parametrised lobby/countdown controller. Watches N per-player ready flags and starts a countdown once enough players are ready, then releases the race.
- Adds three things: abort on un-ready, a race-over return to lobby, and start/abort pulses.
- Sits between the player input blocks and the game core / LED renderer. It drives is_in_menu, countdown digits and an activity strobe for the display.

---
 rtl/race_start_sequencer_pkg.sv | 21 ++
 rtl/race_start_sequencer_tick.sv | 30 +++
 rtl/race_start_sequencer.sv | 119 +++++++++++
 tb/tb_race_start_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/race_start_sequencer_pkg.sv
// Shared types and helpers for the race start sequencer: lobby/countdown/racing
// state encoding and a small popcount used for the ready vector.
package race_start_sequencer_pkg;

   typedef enum logic [1:0] {
      LOBBY    = 2'd0,
      COUNTING = 2'd1,
      RACING   = 2'd2
   } state_t;

   // Ready vectors are at most 8 wide; callers zero-extend narrower vectors.
   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/race_start_sequencer_tick.sv
// Countdown step timer: free-runs only while enabled and emits one tick every
// TICK_CLK_COUNT cycles; cleared whenever disabled.
module race_tick_gen #(
   parameter int TICK_CLK_COUNT = 50000000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int CW = $clog2(TICK_CLK_COUNT);

   logic [CW-1:0] cnt;
   logic          at_end;

   assign at_end = (cnt == CW'(TICK_CLK_COUNT - 1));
   assign tick   = enable && at_end;

   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         cnt <= '0;
      end else if (at_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/race_start_sequencer.sv
// Lobby/countdown controller: starts a countdown once enough players are ready,
// releases the race on the last tick, optionally aborts when readiness drops.
module race_start_sequencer
   import race_start_sequencer_pkg::*;
#(
   parameter int NUM_PLAYERS     = 4,
   parameter int MIN_READY       = NUM_PLAYERS,
   parameter int COUNTDOWN_START = 7,
   parameter int CNT_W           = 3,
   parameter int TICK_CLK_COUNT  = 50000000,
   parameter int ABORT_EN        = 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_PLAYERS-1:0]             ready,
   input  logic                               race_over,
   output logic                               is_in_menu,
   output logic [CNT_W-1:0]                   countdown,
   output logic [$clog2(NUM_PLAYERS+1)-1:0]   ready_count,
   output logic                               activity,
   output logic                               race_start,
   output logic                               aborted
);

   localparam int RCW = $clog2(NUM_PLAYERS + 1);

   if (MIN_READY < 1 || MIN_READY > NUM_PLAYERS || COUNTDOWN_START < 1 ||
       COUNTDOWN_START >= (1 << CNT_W) || NUM_PLAYERS < 1 || NUM_PLAYERS > 8 ||
       TICK_CLK_COUNT < 2) begin : g_bad_params
      $error("race_start_sequencer: illegal parameter combination");
   end

   state_t           state;
   state_t           state_nxt;
   logic [RCW-1:0]   rc_q;
   logic [CNT_W-1:0] cd_q;
   logic             race_start_q;
   logic             aborted_q;
   logic             start_ok;
   logic             tick;
   logic             abort_now;
   logic             finish_now;
   logic [7:0]       ready_ext;

   assign ready_ext = 8'(ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         rc_q <= '0;
      end else begin
         rc_q <= RCW'(popcount8(ready_ext));
      end
   end

   // Start/abort decisions use the registered count, never the raw inputs.
   assign start_ok   = (rc_q >= RCW'(MIN_READY));
   assign abort_now  = (state == COUNTING) && (ABORT_EN != 0) && !start_ok;
   assign finish_now = (state == COUNTING) && !abort_now && tick &&
                       (cd_q == CNT_W'(1));

   race_tick_gen #(
      .TICK_CLK_COUNT(TICK_CLK_COUNT)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .enable (state == COUNTING),
      .tick   (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LOBBY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOBBY:    if (start_ok) state_nxt = COUNTING;
         COUNTING: if (abort_now || finish_now) state_nxt = (abort_now ? LOBBY : RACING);
         RACING:   if (race_over) state_nxt = LOBBY;
         default:  state_nxt = LOBBY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cd_q         <= '0;
         race_start_q <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         race_start_q <= finish_now;
         aborted_q    <= abort_now;
         case (state)
            LOBBY:    cd_q <= start_ok ? CNT_W'(COUNTDOWN_START) : '0;
            COUNTING: begin
               if (abort_now || finish_now) begin
                  cd_q <= '0;
               end else if (tick) begin
                  cd_q <= cd_q - CNT_W'(1);
               end
            end
            default:  cd_q <= '0;
         endcase
      end
   end

   always_comb begin
      is_in_menu  = (state != RACING);
      countdown   = cd_q;
      ready_count = rc_q;
      activity    = tick;
      race_start  = race_start_q;
      aborted     = aborted_q;
   end

endmodule

// File: tb/tb_race_start_sequencer.sv
// Drives three sequencer configurations with shared directed and random stimulus
// and compares every output each cycle against an elapsed-time model.
module tb_race_start_sequencer;

   localparam int NP   = 4;
   localparam int MINR = 2;
   localparam int TK   = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       race_over = 1'b0;
   logic [3:0] ready = 4'hF;

   logic       menu [3];
   logic [2:0] cd   [3];
   logic [2:0] rcnt [3];
   logic       act  [3];
   logic       rs   [3];
   logic       ab   [3];

   int m_st [3];
   int m_ab [3];
   int ph   [3];
   int el   [3];
   int rc   [3];
   int ab_p [3];
   int st_p [3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   race_start_sequencer #(.NUM_PLAYERS(NP), .MIN_READY(MINR), .COUNTDOWN_START(3),
      .CNT_W(3), .TICK_CLK_COUNT(TK), .ABORT_EN(1)) u0 (
      .clk(clk), .reset(reset), .ready(ready), .race_over(race_over),
      .is_in_menu(menu[0]), .countdown(cd[0]), .ready_count(rcnt[0]),
      .activity(act[0]), .race_start(rs[0]), .aborted(ab[0]));

   race_start_sequencer #(.NUM_PLAYERS(NP), .MIN_READY(MINR), .COUNTDOWN_START(3),
      .CNT_W(3), .TICK_CLK_COUNT(TK), .ABORT_EN(0)) u1 (
      .clk(clk), .reset(reset), .ready(ready), .race_over(race_over),
      .is_in_menu(menu[1]), .countdown(cd[1]), .ready_count(rcnt[1]),
      .activity(act[1]), .race_start(rs[1]), .aborted(ab[1]));

   race_start_sequencer #(.NUM_PLAYERS(NP), .MIN_READY(MINR), .COUNTDOWN_START(1),
      .CNT_W(3), .TICK_CLK_COUNT(TK), .ABORT_EN(1)) u2 (
      .clk(clk), .reset(reset), .ready(ready), .race_over(race_over),
      .is_in_menu(menu[2]), .countdown(cd[2]), .ready_count(rcnt[2]),
      .activity(act[2]), .race_start(rs[2]), .aborted(ab[2]));

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int pop4(input logic [3:0] v);
      return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
   endfunction

   // Phases: 0 lobby, 1 counting (el = cycles spent counting), 2 racing.
   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            ph[i] = 0; el[i] = 0; rc[i] = 0; ab_p[i] = 0; st_p[i] = 0;
         end else begin
            ab_p[i] = 0;
            st_p[i] = 0;
            if (ph[i] == 0) begin
               if (rc[i] >= MINR) begin ph[i] = 1; el[i] = 0; end
            end else if (ph[i] == 1) begin
               if (m_ab[i] != 0 && rc[i] < MINR) begin
                  ph[i] = 0; ab_p[i] = 1;
               end else if (el[i] + 1 == m_st[i] * TK) begin
                  ph[i] = 2; st_p[i] = 1;
               end else begin
                  el[i] = el[i] + 1;
               end
            end else if (race_over) begin
               ph[i] = 0;
            end
            rc[i] = pop4(ready);
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d.is_in_menu", i), int'(menu[i]), (ph[i] != 2) ? 1 : 0);
         chk($sformatf("u%0d.countdown", i), int'(cd[i]),
             (ph[i] == 1) ? (m_st[i] - el[i] / TK) : 0);
         chk($sformatf("u%0d.ready_count", i), int'(rcnt[i]), rc[i]);
         chk($sformatf("u%0d.activity", i), int'(act[i]),
             (ph[i] == 1 && (el[i] % TK) == TK - 1) ? 1 : 0);
         chk($sformatf("u%0d.race_start", i), int'(rs[i]), st_p[i]);
         chk($sformatf("u%0d.aborted", i), int'(ab[i]), ab_p[i]);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic ro, input logic rst);
      ready     = r;
      race_over = ro;
      reset     = rst;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      logic [3:0] r;
      logic       ro;
      logic       rst;
      m_st[0] = 3; m_ab[0] = 1;
      m_st[1] = 3; m_ab[1] = 0;
      m_st[2] = 1; m_ab[2] = 1;

      // Reset with all players ready, then release and watch the count appear.
      repeat (3) step(4'hF, 1'b0, 1'b1);
      step(4'hF, 1'b0, 1'b0);
      repeat (3) step(4'h0, 1'b0, 1'b0);

      // Full countdown into racing, race_over back to lobby and straight restart.
      repeat (18) step(4'h3, 1'b0, 1'b0);
      step(4'h3, 1'b1, 1'b0);
      repeat (6) step(4'h3, 1'b0, 1'b0);
      step(4'h3, 1'b1, 1'b0);
      repeat (5) step(4'h1, 1'b0, 1'b0);
      repeat (20) step(4'h3, 1'b0, 1'b0);
      step(4'h3, 1'b1, 1'b0);
      repeat (4) step(4'h3, 1'b0, 1'b0);
      step(4'h3, 1'b0, 1'b1);
      repeat (3) step(4'h3, 1'b0, 1'b0);

      // Sweep the ready drop across every countdown cycle, including the final tick.
      for (int off = 0; off < 16; off++) begin
         step(4'h0, 1'b0, 1'b1);
         repeat (off + 1) step(4'h3, 1'b0, 1'b0);
         repeat (3) step(4'h1, 1'b0, 1'b0);
         repeat (2) step(4'h0, 1'b0, 1'b0);
      end

      r = 4'h3;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) r = 4'($urandom);
         ro  = ($urandom_range(0, 9) == 0);
         rst = ($urandom_range(0, 199) == 0);
         step(r, ro, rst);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
